// File: rtl/gemm_pkg.sv
// Shared GEMM constants, tile_writer state encoding and tile types.
// Imported by the tile writer, its address generator and the matrix reader side.
package gemm_pkg;

    localparam int SQ_DIM         = 4;
    localparam int OUT_DATA_WIDTH = 32;
    localparam int ADDR_WIDTH     = 16;
    localparam int GEOM_WIDTH     = 16;

    typedef enum logic [1:0] {
        TW_IDLE  = 2'd0,
        TW_WRITE = 2'd1,
        TW_DONE  = 2'd2
    } tw_state_t;

    typedef logic signed [SQ_DIM-1:0][SQ_DIM-1:0][OUT_DATA_WIDTH-1:0] out_tile_t;

    // Linear address of tile element [0][0]; callers truncate to their address width.
    function automatic logic [31:0] tile_start_addr(
        input logic [31:0]           base,
        input logic [GEOM_WIDTH-1:0] row,
        input logic [GEOM_WIDTH-1:0] cols,
        input logic [GEOM_WIDTH-1:0] col
    );
        return base + (32'(row) * 32'(cols)) + 32'(col);
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row/column counter with a row-stride address accumulator for walking a
// sqDim x sqDim tile row-major; loaded on start, stepped on advance.
module tile_addr_gen
    import gemm_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int sqDim     = SQ_DIM,
    parameter int IdxWidth  = (sqDim > 1) ? $clog2(sqDim) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  start_addr_i,
    input  logic [GEOM_WIDTH-1:0] stride_i,
    input  logic                  advance_i,
    output logic [AddrWidth-1:0]  addr_o,
    output logic [IdxWidth-1:0]   row_o,
    output logic [IdxWidth-1:0]   col_o,
    output logic                  last_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(sqDim - 1);

    logic [IdxWidth-1:0]   row_reg;
    logic [IdxWidth-1:0]   col_reg;
    logic [AddrWidth-1:0]  row_addr_reg;
    logic [GEOM_WIDTH-1:0] stride_reg;
    logic                  last_col;

    assign last_col = (col_reg == LastIdx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_reg      <= '0;
            col_reg      <= '0;
            row_addr_reg <= '0;
            stride_reg   <= '0;
        end else if (start_i) begin
            row_reg      <= '0;
            col_reg      <= '0;
            row_addr_reg <= start_addr_i;
            stride_reg   <= stride_i;
        end else if (advance_i) begin
            if (last_col) begin
                col_reg      <= '0;
                row_reg      <= row_reg + 1'b1;
                // Sum at 32 bits so the truncation wraps modulo 2^AddrWidth.
                row_addr_reg <= AddrWidth'(32'(row_addr_reg) + 32'(stride_reg));
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign addr_o = AddrWidth'(32'(row_addr_reg) + 32'(col_reg));
    assign row_o  = row_reg;
    assign col_o  = col_reg;
    assign last_o = last_col && (row_reg == LastIdx);

endmodule

// File: rtl/tile_writer.sv
// Streams one latched sqDim x sqDim result tile into row-major memory C,
// one element per accepted write, honouring memory back-pressure.
module tile_writer
    import gemm_pkg::*;
#(
    parameter int AddrWidth    = ADDR_WIDTH,
    parameter int OutDataWidth = OUT_DATA_WIDTH,
    parameter int sqDim        = SQ_DIM
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              start_i,
    input  logic [AddrWidth-1:0]                              base_addr_i,
    input  logic [GEOM_WIDTH-1:0]                             matrix_cols_i,
    input  logic [GEOM_WIDTH-1:0]                             start_row_i,
    input  logic [GEOM_WIDTH-1:0]                             start_col_i,
    input  logic signed [sqDim-1:0][sqDim-1:0][OutDataWidth-1:0] tile_i,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic [AddrWidth-1:0]                              mem_addr_o,
    output logic [OutDataWidth-1:0]                           mem_wr_data_o,
    output logic                                              mem_we_o,
    input  logic                                              mem_ready_i
);

    localparam int IdxWidth = (sqDim > 1) ? $clog2(sqDim) : 1;

    tw_state_t state_reg;
    logic      busy_reg;
    logic      done_reg;
    logic signed [sqDim-1:0][sqDim-1:0][OutDataWidth-1:0] tile_reg;

    logic                 launch;
    logic                 accept;
    logic [AddrWidth-1:0] gen_addr;
    logic [IdxWidth-1:0]  gen_row;
    logic [IdxWidth-1:0]  gen_col;
    logic                 gen_last;

    assign launch = (state_reg == TW_IDLE) && start_i;
    assign accept = busy_reg && mem_ready_i;

    tile_addr_gen #(
        .AddrWidth (AddrWidth),
        .sqDim     (sqDim),
        .IdxWidth  (IdxWidth)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (launch),
        .start_addr_i (AddrWidth'(tile_start_addr(32'(base_addr_i), start_row_i,
                                                  matrix_cols_i, start_col_i))),
        .stride_i     (matrix_cols_i),
        .advance_i    (accept),
        .addr_o       (gen_addr),
        .row_o        (gen_row),
        .col_o        (gen_col),
        .last_o       (gen_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= TW_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            tile_reg  <= '0;
        end else begin
            case (state_reg)
                TW_IDLE: begin
                    done_reg <= 1'b0;
                    if (start_i) begin
                        tile_reg  <= tile_i;
                        busy_reg  <= 1'b1;
                        state_reg <= TW_WRITE;
                    end
                end
                TW_WRITE: begin
                    if (accept && gen_last) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= TW_DONE;
                    end
                end
                TW_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= TW_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= TW_IDLE;
                end
            endcase
        end
    end

    // busy_reg mirrors the WRITE state, so it gates the memory port directly.
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign mem_we_o      = busy_reg;
    assign mem_addr_o    = busy_reg ? gen_addr : '0;
    assign mem_wr_data_o = busy_reg ? tile_reg[gen_row][gen_col] : '0;

endmodule

// File: doc/tile_writer.md
# tile_writer

Writes one sqDim x sqDim tile of OutDataWidth-bit results from the MAC array into a row-major matrix in single-port memory C. Writes go one element per accepted cycle, at row-stride addresses. It is the write-side counterpart of `matrix_reader` and uses the same geometry arguments: base, matrix column count, start row and start column. It replaces the inline C-write loop in the GEMM controller and adds memory back-pressure.

## Interface
- AddrWidth, 16, memory address width
- OutDataWidth, 32, element width (signed)
- sqDim, 4, tile edge; tile holds sqDim*sqDim elements
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  request; sampled only in IDLE
- base_addr_i  in  AddrWidth  matrix base address
- matrix_cols_i  in  16  row stride (matrix column count)
- start_row_i  in  16  global row of tile element [0][0]
- start_col_i  in  16  global column of tile element [0][0]
- tile_i  in  sqDim x sqDim x OutDataWidth  signed packed tile, indexed [row][col]
- busy_o  out  1  high while writes are pending
- done_o  out  1  one-cycle completion pulse
- mem_addr_o  out  AddrWidth  write address
- mem_wr_data_o  out  OutDataWidth  write data
- mem_we_o  out  1  write request
- mem_ready_i  in  1  memory accepts the write this cycle when mem_we_o && mem_ready_i

## Operation
- States: IDLE, WRITE, DONE. Encoding is defined in the shared package.
- IDLE:
  - If start_i is high, latch tile_i, matrix_cols_i and the start address into internal registers, then go to WRITE.
  - Start address = base_addr_i + start_row_i*matrix_cols_i + start_col_i.
- WRITE:
  - Drive mem_we_o = 1.
  - mem_addr_o = row_addr + c.
  - mem_wr_data_o = latched tile[r][c].
  - Order is row-major: r outer loop, c inner loop, both starting at 0.
- Element advance happens only on accept (mem_we_o && mem_ready_i):
  - Accept with c < sqDim-1: c increments.
  - Accept with c = sqDim-1: c resets to 0, r increments, row_addr += latched cols.
  - Accept of element [sqDim-1][sqDim-1]: go to DONE.
- DONE: done_o = 1 for exactly one cycle, then go to IDLE unconditionally.
- start_i in WRITE or DONE is ignored. A new start_i is first honoured in the IDLE cycle after DONE.
- Changes on tile_i or the geometry inputs after the start cycle have no effect on the transfer in progress.
- Arithmetic and width rules:
  - Compute addresses at ≥32 bits, then truncate to AddrWidth, so addresses wrap modulo 2^AddrWidth.
  - Use at most one multiply, in IDLE at start. Per-element address updates are adds only.
- Outside WRITE: mem_we_o = 0, mem_addr_o = 0, mem_wr_data_o = 0.
- busy_o = (state == WRITE).
- matrix_cols_i = 0 is legal: every row then targets the same sqDim addresses. No error is flagged.

## Timing
- Reset values: every output is 0, state = IDLE, and all counters and latches are 0.
- Reset asserted mid-transfer: outputs go to 0 asynchronously. The transfer is abandoned and no write is issued after release.
- Start sampled at edge 0:
  - First write is presented in cycle 1.
  - With mem_ready_i held high, writes occupy cycles 1..sqDim², and done_o is high in cycle sqDim²+1 (cycle 17 for sqDim = 4).
- Each cycle with mem_ready_i low in WRITE adds one cycle of latency. Address and data stay stable while the write is not accepted.
- Minimum start-to-start spacing is sqDim²+2 cycles (WRITE, then DONE, then IDLE).

## Structure
- Shared package gemm_pkg holds:
  - sqDim default and data-width constants
  - the tile_writer state enum
  - a packed tile typedef for OutDataWidth tiles
- One natural sub-module, tile_addr_gen. It is a row/column counter plus row-stride address accumulator with start/advance/last outputs, and is reusable by `matrix_reader`.

## Test plan
- Basic write:
  - Stimulus: base = 0x100, cols = 8, start_row = 4, start_col = 4, tile[r][c] = r*4+c, mem_ready_i = 1.
  - Required: writes to 0x124..0x127, 0x12C..0x12F, 0x134..0x137, 0x13C..0x13F with data 0..15 in cycles 1..16, done_o in cycle 17, busy_o in cycles 1..16.
- Back-pressure:
  - Stimulus: same setup, mem_ready_i low for 3 cycles while element 5 (address 0x12D) is presented.
  - Required: address 0x12D and data 5 held for 4 cycles, no element skipped or duplicated, done_o in cycle 20.
- Start while busy:
  - Stimulus: pulse start_i in cycle 5 with a different tile_i and base.
  - Required: the original 16 writes are unchanged, and exactly one done_o pulse occurs.
- Address wrap:
  - Stimulus: AddrWidth = 16, base = 0xFFFE, cols = 4, start_row = 0, start_col = 0.
  - Required: first row writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-operation:
  - Stimulus: drop rst_ni after 6 accepted writes, release after 2 cycles.
  - Required: all outputs 0 immediately, state IDLE, no writes until the next start_i.
- Signed data:
  - Stimulus: tile[0][0] = -1, tile[3][3] = 0x7FFFFFFF.
  - Required: mem_wr_data_o = 0xFFFFFFFF and 0x7FFFFFFF at the matching addresses.
